pwm_duty_seq: RTL and testbench

- Upstream duty-word sequencer for pwm_gen; its o_w drives pwm_gen's i_w.
- Steps a W-bit duty value once every i_step_div clocks, with four modes: hold, ramp-up, ramp-down and triangle ("breathing").
- Supports a synchronous load of an arbitrary duty value.
- Flags report saturation and direction to control logic and the bench.

---
 rtl/pwm_duty_seq.sv | 105 ++++++++++
 tb/tb_pwm_duty_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_seq.sv
// Duty-word sequencer feeding pwm_gen: steps a W-bit duty value every
// i_step_div clocks in hold, ramp-up, ramp-down or triangle mode.
//
// state | meaning
// UP    | triangle counting toward MAX (o_dir=1)
// DOWN  | triangle counting toward 0   (o_dir=0)
module pwm_duty_seq #(
    parameter int W     = 4,
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_step_div,
    input  logic             i_load,
    input  logic [W-1:0]     i_load_w,
    output logic [W-1:0]     o_w,
    output logic             o_dir,
    output logic             o_step,
    output logic             o_at_max,
    output logic             o_at_min
);

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    localparam logic [W-1:0] MAX   = '1;
    localparam logic [W:0]   MAX_X = {1'b0, MAX};

    dir_t             dir_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1;
    logic             tick;
    logic [W:0]       w_inc;
    logic [W:0]       w_dec;
    logic [W-1:0]     w_up;
    logic [W-1:0]     w_dn;

    // A zero divider behaves as one, so div_m1 is zero in both cases.
    assign div_m1 = (i_step_div == '0) ? '0 : (i_step_div - DIV_W'(1));
    assign tick   = i_en && (cnt >= div_m1);

    // Saturating +/-1 in W+1 bits so the limits never wrap.
    assign w_inc = {1'b0, o_w} + (W+1)'(1);
    assign w_dec = {1'b0, o_w} - (W+1)'(1);
    assign w_up  = (w_inc > MAX_X) ? MAX : w_inc[W-1:0];
    assign w_dn  = w_dec[W] ? '0 : w_dec[W-1:0];

    assign o_dir    = (dir_q == UP);
    assign o_at_max = (o_w == MAX);
    assign o_at_min = (o_w == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_w    <= '0;
            dir_q  <= UP;
            o_step <= 1'b0;
            cnt    <= '0;
        end else begin
            o_step <= 1'b0;
            if (i_load) begin
                // Load discards any coincident tick.
                o_w <= i_load_w;
                cnt <= '0;
                if (i_load_w == MAX)
                    dir_q <= DOWN;
                else if (i_load_w == '0)
                    dir_q <= UP;
            end else if (!i_en) begin
                cnt <= '0;
            end else if (tick) begin
                cnt    <= '0;
                o_step <= 1'b1;
                case (i_mode)
                    2'b00: o_w <= o_w;
                    2'b01: o_w <= w_up;
                    2'b10: o_w <= w_dn;
                    default: begin
                        if (dir_q == UP) begin
                            if (o_w == MAX) begin
                                dir_q <= DOWN;
                                o_w   <= w_dn;
                            end else begin
                                o_w <= w_up;
                            end
                        end else begin
                            if (o_w == '0) begin
                                dir_q <= UP;
                                o_w   <= w_up;
                            end else begin
                                o_w <= w_dn;
                            end
                        end
                    end
                endcase
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed from the step rules.
module tb_pwm_duty_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] step_div = 16'd1;
    logic        load = 1'b0;
    logic [3:0]  load_w = 4'd0;
    logic [3:0]  w;
    logic        dir;
    logic        step;
    logic        at_max;
    logic        at_min;

    int checks = 0;
    int failures = 0;

    pwm_duty_seq #(.W(4), .DIV_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_mode     (mode),
        .i_step_div (step_div),
        .i_load     (load),
        .i_load_w   (load_w),
        .o_w        (w),
        .o_dir      (dir),
        .o_step     (step),
        .o_at_max   (at_max),
        .o_at_min   (at_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Each call lets n rising edges pass and returns on a falling edge.
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] v);
        load   = 1'b1;
        load_w = v;
        edges(1);
        load   = 1'b0;
    endtask

    initial begin
        edges(2);
        chk("rst_w", w, 0);
        chk("rst_dir", dir, 1);
        chk("rst_step", step, 0);
        chk("rst_at_min", at_min, 1);
        chk("rst_at_max", at_max, 0);
        rst_n = 1'b1;
        edges(1);

        // Ramp-up at div 50: one step every 50 clocks, saturating at 15.
        en = 1'b1; mode = 2'b01; step_div = 16'd50;
        edges(49);
        chk("ramp_pre_w", w, 0);
        chk("ramp_pre_step", step, 0);
        for (int k = 1; k <= 16; k++) begin
            edges(1);
            chk($sformatf("ramp_w_%0d", k), w, (k > 15) ? 15 : k);
            chk($sformatf("ramp_step_%0d", k), step, 1);
            if (k < 16) begin
                edges(49);
                chk($sformatf("ramp_gap_step_%0d", k), step, 0);
            end
        end
        chk("ramp_at_max", at_max, 1);

        // Triangle at div 1 from 0: period 30, direction flips on 15->14.
        mode = 2'b11; step_div = 16'd1;
        do_load(4'd0);
        chk("tri_load_w", w, 0);
        chk("tri_load_dir", dir, 1);
        for (int k = 1; k <= 31; k++) begin
            edges(1);
            chk($sformatf("tri_w_%0d", k), w, (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30));
            chk($sformatf("tri_dir_%0d", k), dir, (k >= 16 && k <= 30) ? 0 : 1);
        end

        // Divider 0 acts as 1: ramp-down from 5 every clock, then sticks at 0.
        mode = 2'b10; step_div = 16'd0;
        do_load(4'd5);
        chk("dn_load_w", w, 5);
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            chk($sformatf("dn_w_%0d", k), w, (k <= 5) ? 5 - k : 0);
            chk($sformatf("dn_step_%0d", k), step, 1);
        end
        chk("dn_at_min", at_min, 1);

        // Load coincident with a pending tick wins; next tick 4 clocks later.
        mode = 2'b01; step_div = 16'd4;
        do_load(4'd3);
        edges(3);
        chk("ld_pre_w", w, 3);
        chk("ld_pre_step", step, 0);
        do_load(4'd9);
        chk("ld_w", w, 9);
        chk("ld_step", step, 0);
        edges(3);
        chk("ld_gap_w", w, 9);
        chk("ld_gap_step", step, 0);
        edges(1);
        chk("ld_next_w", w, 10);
        chk("ld_next_step", step, 1);

        // Enable low for 20 clocks mid-interval: frozen, no pulses, cnt cleared.
        edges(2);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            edges(1);
            chk($sformatf("dis_w_%0d", k), w, 10);
            chk($sformatf("dis_step_%0d", k), step, 0);
        end
        en = 1'b1;
        edges(3);
        chk("reen_gap_w", w, 10);
        edges(1);
        chk("reen_w", w, 11);
        chk("reen_step", step, 1);

        // Divider shrinking below the running count ticks on the next edge.
        step_div = 16'd50;
        edges(10);
        chk("shrink_pre_w", w, 11);
        step_div = 16'd4;
        edges(1);
        chk("shrink_w", w, 12);
        chk("shrink_step", step, 1);

        // Hold mode still pulses o_step but leaves o_w alone.
        mode = 2'b00; step_div = 16'd2;
        edges(1);
        chk("hold_gap_step", step, 0);
        edges(1);
        chk("hold_step", step, 1);
        chk("hold_w", w, 12);

        // Loading MAX points the triangle downward; loading mid-range keeps it.
        do_load(4'd15);
        chk("ldmax_dir", dir, 0);
        chk("ldmax_at_max", at_max, 1);
        do_load(4'd7);
        chk("ldmid_dir", dir, 0);
        chk("ldmid_w", w, 7);

        // Asynchronous reset between edges takes effect immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_w", w, 0);
        chk("arst_dir", dir, 1);
        chk("arst_at_min", at_min, 1);
        chk("arst_step", step, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
